// File: rtl/data_mem_ws.sv
// Wait-state data memory for the multicycle RV32 core: byte/half/word loads and stores,
// a configurable access latency, and a one-cycle ready/error completion pulse.
module data_mem_ws #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           dAddress,
  input  logic [DATA_WIDTH-1:0] dWriteData,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] dReadData,
  output logic                  mem_ready,
  output logic                  mem_err
);

  localparam int         DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [2:0]              f3_q, f3_d;
  logic                    rd_q, rd_d;
  logic                    wr_q, wr_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  // Only the word index and byte lane matter; higher address bits wrap.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^dAddress[31:ADDR_WIDTH+2];

  // In IDLE the access may complete on this very edge (no wait states),
  // so the live inputs are used; otherwise the captured request.
  logic                    sel_idle;
  logic [ADDR_WIDTH+1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [2:0]              acc_f3;
  logic                    acc_rd, acc_wr, acc_err;
  logic [1:0]              lane;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [DATA_WIDTH-1:0]   mem_word, load_val, store_word, store_rep;
  logic [3:0]              store_be;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic                    commit, mem_we;

  always_comb begin
    sel_idle  = (state_q == IDLE);
    acc_addr  = sel_idle ? dAddress[ADDR_WIDTH+1:0] : addr_q;
    acc_wdata = sel_idle ? dWriteData : wdata_q;
    acc_f3    = sel_idle ? funct3 : f3_q;
    acc_rd    = sel_idle ? MemRead : rd_q;
    acc_wr    = sel_idle ? MemWrite : wr_q;
    lane      = acc_addr[1:0];
    idx       = acc_addr[ADDR_WIDTH+1:2];
    mem_word  = mem[idx];

    acc_err = 1'b0;
    if (acc_rd && acc_wr) begin
      acc_err = 1'b1;
    end else if (acc_wr) begin
      case (acc_f3)
        3'b000:  acc_err = 1'b0;
        3'b001:  acc_err = lane[0];
        3'b010:  acc_err = (lane != 2'b00);
        default: acc_err = 1'b1;
      endcase
    end else if (acc_rd) begin
      case (acc_f3)
        3'b000, 3'b100: acc_err = 1'b0;
        3'b001, 3'b101: acc_err = lane[0];
        3'b010:         acc_err = (lane != 2'b00);
        default:        acc_err = 1'b1;
      endcase
    end

    case (lane)
      2'd0:    byte_sel = mem_word[7:0];
      2'd1:    byte_sel = mem_word[15:8];
      2'd2:    byte_sel = mem_word[23:16];
      default: byte_sel = mem_word[31:24];
    endcase
    half_sel = lane[1] ? mem_word[31:16] : mem_word[15:0];

    case (acc_f3)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = mem_word;
    endcase

    case (acc_f3)
      3'b000: begin
        store_be  = 4'b0001 << lane;
        store_rep = {4{acc_wdata[7:0]}};
      end
      3'b001: begin
        store_be  = lane[1] ? 4'b1100 : 4'b0011;
        store_rep = {2{acc_wdata[15:0]}};
      end
      default: begin
        store_be  = 4'b1111;
        store_rep = acc_wdata;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      store_word[i*8 +: 8] = store_be[i] ? store_rep[i*8 +: 8] : mem_word[i*8 +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    commit  = 1'b0;

    case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d  = dAddress[ADDR_WIDTH+1:0];
          wdata_d = dWriteData;
          f3_d    = funct3;
          rd_d    = MemRead;
          wr_d    = MemWrite;
          if (WS == 4'd0) begin
            state_d = DONE;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WS) begin
          state_d = DONE;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Reads and writes both take effect on the edge that enters DONE.
    if (commit) begin
      err_d = acc_err;
      if (acc_rd && !acc_err) rdata_d = load_val;
    end
    mem_we = commit && acc_wr && !acc_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Array is never cleared; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[idx] <= store_word;
  end

  assign dReadData = rdata_q;
  assign mem_ready = (state_q == DONE);
  assign mem_err   = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_data_mem_ws.sv
// Directed bench for data_mem_ws: a 2-wait-state instance driven from a vector table plus
// hand sequences, and a 0-wait-state instance for back-to-back and read+write collisions.
module tb_data_mem_ws;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] dAddress = '0, dWriteData = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] dReadData;
  logic        mem_ready, mem_err;

  logic        MemRead0 = 1'b0, MemWrite0 = 1'b0;
  logic [31:0] dAddress0 = '0, dWriteData0 = '0;
  logic [2:0]  funct30 = '0;
  logic [31:0] dReadData0;
  logic        mem_ready0, mem_err0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_mem_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .dAddress(dAddress), .dWriteData(dWriteData), .funct3(funct3),
    .dReadData(dReadData), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  data_mem_ws #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .MemRead(MemRead0), .MemWrite(MemWrite0),
    .dAddress(dAddress0), .dWriteData(dWriteData0), .funct3(funct30),
    .dReadData(dReadData0), .mem_ready(mem_ready0), .mem_err(mem_err0)
  );

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    bit          exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // One access on the 2-wait-state instance: latency, error flag, load data, ready drop.
  task automatic run_vec(input vec_t v, input string tag);
    int n;
    @(negedge clk);
    MemRead = v.rd; MemWrite = v.wr; dAddress = v.addr; dWriteData = v.wdata; funct3 = v.f3;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    n = 0;
    while (!mem_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd2);
    chk({tag, "_err"}, {31'd0, mem_err}, {31'd0, v.exp_err});
    chk({tag, "_rdata"}, dReadData, v.exp_rdata);
    @(negedge clk);
    chk({tag, "_ready_drop"}, {31'd0, mem_ready}, 32'd0);
  endtask

  function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [2:0] f3,
                              input bit exp_err, input logic [31:0] exp_rdata);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.f3 = f3;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata;
    return v;
  endfunction

  initial begin
    // rd, wr, addr, wdata, f3, exp_err, exp_rdata
    vecs.push_back(mk(0, 1, 32'h10,   32'hDEADBEEF, 3'b010, 0, 32'h00000000)); // SW
    vecs.push_back(mk(1, 0, 32'h10,   32'h0,        3'b010, 0, 32'hDEADBEEF)); // LW
    vecs.push_back(mk(0, 1, 32'h13,   32'h00000080, 3'b000, 0, 32'hDEADBEEF)); // SB
    vecs.push_back(mk(1, 0, 32'h13,   32'h0,        3'b000, 0, 32'hFFFFFF80)); // LB
    vecs.push_back(mk(1, 0, 32'h13,   32'h0,        3'b100, 0, 32'h00000080)); // LBU
    vecs.push_back(mk(1, 0, 32'h10,   32'h0,        3'b010, 0, 32'h80ADBEEF)); // LW
    vecs.push_back(mk(1, 0, 32'h11,   32'h0,        3'b001, 1, 32'h80ADBEEF)); // LH misaligned
    vecs.push_back(mk(0, 1, 32'h12,   32'h55555555, 3'b010, 1, 32'h80ADBEEF)); // SW misaligned
    vecs.push_back(mk(1, 0, 32'h10,   32'h0,        3'b010, 0, 32'h80ADBEEF)); // LW unchanged
    vecs.push_back(mk(0, 1, 32'h14,   32'h11223344, 3'b010, 0, 32'h80ADBEEF)); // SW
    vecs.push_back(mk(0, 1, 32'h16,   32'h9999CAFE, 3'b001, 0, 32'h80ADBEEF)); // SH upper
    vecs.push_back(mk(1, 0, 32'h16,   32'h0,        3'b001, 0, 32'hFFFFCAFE)); // LH
    vecs.push_back(mk(1, 0, 32'h16,   32'h0,        3'b101, 0, 32'h0000CAFE)); // LHU
    vecs.push_back(mk(1, 0, 32'h14,   32'h0,        3'b000, 0, 32'h00000044)); // LB lane0
    vecs.push_back(mk(1, 0, 32'h14,   32'h0,        3'b010, 0, 32'hCAFE3344)); // LW
    vecs.push_back(mk(1, 0, 32'h14,   32'h0,        3'b011, 1, 32'hCAFE3344)); // load f3=011
    vecs.push_back(mk(0, 1, 32'h14,   32'h000000EE, 3'b100, 1, 32'hCAFE3344)); // store f3=100
    vecs.push_back(mk(1, 1, 32'h14,   32'h00000000, 3'b010, 1, 32'hCAFE3344)); // rd+wr
    vecs.push_back(mk(1, 0, 32'h14,   32'h0,        3'b010, 0, 32'hCAFE3344)); // LW unchanged
    vecs.push_back(mk(0, 1, 32'h1000, 32'h12345678, 3'b010, 0, 32'hCAFE3344)); // SW wraps
    vecs.push_back(mk(1, 0, 32'h0,    32'h0,        3'b010, 0, 32'h12345678)); // LW 0
    vecs.push_back(mk(1, 0, 32'h1003, 32'h0,        3'b100, 0, 32'h00000012)); // LBU wrap

    // Clock/reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d_rdata", i), dReadData, 32'd0);
      chk($sformatf("idle%0d_ready", i), {31'd0, mem_ready}, 32'd0);
      chk($sformatf("idle%0d_err", i), {31'd0, mem_err}, 32'd0);
      chk($sformatf("idle%0d_ready0", i), {31'd0, mem_ready0}, 32'd0);
    end

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset asserted while the SW to 0x0 is still waiting: no write, no pulse.
    @(negedge clk);
    MemWrite = 1'b1; dAddress = 32'h0; dWriteData = 32'hFFFFFFFF; funct3 = 3'b010;
    @(negedge clk);
    MemWrite = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_rdata", dReadData, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rst_mid_ready%0d", i), {31'd0, mem_ready}, 32'd0);
    end
    run_vec(mk(1, 0, 32'h0, 32'h0, 3'b010, 0, 32'h12345678), "rst_mid_lw");

    // Zero-wait-state instance: store, then a held read pulses ready every other cycle.
    @(negedge clk);
    MemWrite0 = 1'b1; dAddress0 = 32'h8; dWriteData0 = 32'hA5A5A5A5; funct30 = 3'b010;
    @(negedge clk);
    MemWrite0 = 1'b0;
    chk("ws0_sw_ready", {31'd0, mem_ready0}, 32'd1);
    chk("ws0_sw_err", {31'd0, mem_err0}, 32'd0);
    @(negedge clk);
    chk("ws0_sw_ready_drop", {31'd0, mem_ready0}, 32'd0);
    MemRead0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ws0_held_ready%0d", i), {31'd0, mem_ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    MemRead0 = 1'b0;
    chk("ws0_held_rdata", dReadData0, 32'hA5A5A5A5);

    @(negedge clk);
    MemRead0 = 1'b1; MemWrite0 = 1'b1; dWriteData0 = 32'h0;
    @(negedge clk);
    MemRead0 = 1'b0; MemWrite0 = 1'b0;
    chk("ws0_rw_ready", {31'd0, mem_ready0}, 32'd1);
    chk("ws0_rw_err", {31'd0, mem_err0}, 32'd1);
    chk("ws0_rw_rdata", dReadData0, 32'hA5A5A5A5);
    @(negedge clk);
    chk("ws0_rw_ready_drop", {31'd0, mem_ready0}, 32'd0);

    @(negedge clk);
    MemRead0 = 1'b1; dAddress0 = 32'h8; funct30 = 3'b000;
    @(negedge clk);
    MemRead0 = 1'b0;
    chk("ws0_lb_ready", {31'd0, mem_ready0}, 32'd1);
    chk("ws0_lb_rdata", dReadData0, 32'hFFFFFFA5);
    @(negedge clk);
    MemRead0 = 1'b1; funct30 = 3'b010;
    @(negedge clk);
    MemRead0 = 1'b0;
    chk("ws0_lw_after_rw", dReadData0, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
